// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default datapath sizes, the hardwired-zero
// register address and the common address/word typedefs.
package mips_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]    reg_addr_t;
  typedef logic [WIDTH_DEF-1:0] word_t;

  localparam reg_addr_t ZERO_REG_ADDR = '0;

endpackage : mips_pkg

// File: rtl/regfile_sb_if.sv
// Decode/issue <-> register file bus: read ports, two writeback ports,
// scoreboard issue request and busy status.
//   master : decode/issue + writeback side (drives addresses, data, issue)
//   slave  : regfile_sb (returns read data, busy flags, stall, busy count)
interface regfile_sb_if #(
  parameter  int unsigned WIDTH = mips_pkg::WIDTH_DEF,
  parameter  int unsigned DEPTH = mips_pkg::DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) ();

  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             busy1;
  logic             busy2;
  logic             we_a;
  logic [AW-1:0]    wa_a;
  logic [WIDTH-1:0] wd_a;
  logic             we_b;
  logic [AW-1:0]    wa_b;
  logic [WIDTH-1:0] wd_b;
  logic             iss_v;
  logic [AW-1:0]    iss_d;
  logic             iss_stall;
  logic             flush;
  logic [AW:0]      busy_cnt;

  modport master (
    output ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_v, iss_d, flush,
    input  rd1, rd2, busy1, busy2, iss_stall, busy_cnt
  );

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_v, iss_d, flush,
    output rd1, rd2, busy1, busy2, iss_stall, busy_cnt
  );

endinterface : regfile_sb_if

// File: rtl/sb_bits.sv
// Scoreboard busy vector. Per-cycle update order: flush clears all, then
// clr_v clears clr_a, then set_v sets set_a. busy_cnt is the registered
// population count of the updated vector.
//   clk, reset_n       : clock, async active-low reset
//   flush              : clear every busy bit
//   clr_v / clr_a      : writeback completion clear
//   set_v / set_a      : accepted issue set (caller masks refused/zero issues)
//   busy               : current registered busy vector
//   busy_cnt           : registered number of busy bits
module sb_bits
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             clr_v,
  input  logic [AW-1:0]    clr_a,
  input  logic             set_v,
  input  logic [AW-1:0]    set_a,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_next;
  logic [AW:0]      w_cnt;

  // Next busy vector in priority order, and its popcount
  always_comb begin
    w_next = r_busy;
    if (flush) w_next = '0;
    if (clr_v) w_next[clr_a] = 1'b0;
    if (set_v) w_next[set_a] = 1'b1;
    w_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + (AW+1)'(w_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_next;
      r_cnt  <= w_cnt;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule : sb_bits

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with same-cycle write bypass and a
// per-register busy scoreboard for issue stalling.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : read ports ra*/rd*/busy*, writeback ports A (ALU) and
//                  B (multicycle/load, also clears busy), issue iss_v/iss_d
//                  with iss_stall, flush, registered busy_cnt
module regfile_sb
  import mips_pkg::*;
#(
  parameter  int unsigned WIDTH    = WIDTH_DEF,
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);

  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG_ADDR);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_we_a;
  logic             w_we_b;
  logic             w_zero1;
  logic             w_zero2;
  logic             w_zero_iss;
  logic             w_clr1;
  logic             w_clr2;
  logic             w_clr_iss;
  logic             w_stall;
  logic             w_set_v;

  // Writes to the hardwired zero register are dropped
  assign w_we_a     = bus.we_a & ~(ZERO_REG && (bus.wa_a == ZADDR));
  assign w_we_b     = bus.we_b & ~(ZERO_REG && (bus.wa_b == ZADDR));
  assign w_zero1    = ZERO_REG && (bus.ra1 == ZADDR);
  assign w_zero2    = ZERO_REG && (bus.ra2 == ZADDR);
  assign w_zero_iss = ZERO_REG && (bus.iss_d == ZADDR);

  // Port B write in this cycle retires the pending destination
  assign w_clr1    = bus.we_b && (bus.wa_b == bus.ra1);
  assign w_clr2    = bus.we_b && (bus.wa_b == bus.ra2);
  assign w_clr_iss = bus.we_b && (bus.wa_b == bus.iss_d);

  assign w_stall = bus.iss_v & w_busy[bus.iss_d] & ~w_clr_iss;
  assign w_set_v = bus.iss_v & ~w_stall & ~w_zero_iss;

  // Storage; port B is written last so it wins an address collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we_a) r_mem[bus.wa_a] <= bus.wd_a;
      if (w_we_b) r_mem[bus.wa_b] <= bus.wd_b;
    end
  end

  // Read muxes: zero register, then B bypass, then A bypass, then storage
  always_comb begin
    bus.rd1 = r_mem[bus.ra1];
    if (w_zero1)                                  bus.rd1 = '0;
    else if (bus.we_b && (bus.wa_b == bus.ra1))   bus.rd1 = bus.wd_b;
    else if (bus.we_a && (bus.wa_a == bus.ra1))   bus.rd1 = bus.wd_a;
  end

  always_comb begin
    bus.rd2 = r_mem[bus.ra2];
    if (w_zero2)                                  bus.rd2 = '0;
    else if (bus.we_b && (bus.wa_b == bus.ra2))   bus.rd2 = bus.wd_b;
    else if (bus.we_a && (bus.wa_a == bus.ra2))   bus.rd2 = bus.wd_a;
  end

  // Register 0 never gets a busy bit, so no extra masking is needed here
  assign bus.busy1     = w_busy[bus.ra1] & ~w_clr1;
  assign bus.busy2     = w_busy[bus.ra2] & ~w_clr2;
  assign bus.iss_stall = w_stall;

  sb_bits #(.DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (bus.flush),
    .clr_v    (bus.we_b),
    .clr_a    (bus.wa_b),
    .set_v    (w_set_v),
    .set_a    (bus.iss_d),
    .busy     (w_busy),
    .busy_cnt (bus.busy_cnt)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .DEPTH(32)) bus ();

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    reg_addr_t ra1, ra2;
    logic      we_a;  reg_addr_t wa_a; word_t wd_a;
    logic      we_b;  reg_addr_t wa_b; word_t wd_b;
    logic      iss_v; reg_addr_t iss_d;
    logic      flush;
    word_t     e_rd1, e_rd2;
    logic      e_b1, e_b2, e_st;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(int ra1, int ra2, int we_a, int wa_a, int wd_a,
                              int we_b, int wa_b, int wd_b, int iss_v, int iss_d,
                              int flush, int e_rd1, int e_rd2, int e_b1, int e_b2,
                              int e_st, int e_cnt);
    vec_t v;
    v.ra1 = 5'(ra1);   v.ra2 = 5'(ra2);
    v.we_a = 1'(we_a); v.wa_a = 5'(wa_a); v.wd_a = 32'(wd_a);
    v.we_b = 1'(we_b); v.wa_b = 5'(wa_b); v.wd_b = 32'(wd_b);
    v.iss_v = 1'(iss_v); v.iss_d = 5'(iss_d); v.flush = 1'(flush);
    v.e_rd1 = 32'(e_rd1); v.e_rd2 = 32'(e_rd2);
    v.e_b1 = 1'(e_b1); v.e_b2 = 1'(e_b2); v.e_st = 1'(e_st);
    v.e_cnt = 6'(e_cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.ra1 = '0; bus.ra2 = '0;
    bus.we_a = 1'b0; bus.wa_a = '0; bus.wd_a = '0;
    bus.we_b = 1'b0; bus.wa_b = '0; bus.wd_b = '0;
    bus.iss_v = 1'b0; bus.iss_d = '0; bus.flush = 1'b0;
  endtask

  initial begin
    //        ra1 ra2 wa  waa wda      wb  wab wdb     iv  id  fl  rd1      rd2      b1 b2 st cnt
    vecs[0]  = mk(5, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0);
    vecs[1]  = mk(5, 5, 1, 5, 'h1234, 0, 0, 0,      0, 0, 0, 'h1234, 'h1234, 0, 0, 0, 0);
    vecs[2]  = mk(5, 7, 0, 0, 0,      0, 0, 0,      0, 0, 0, 'h1234, 0,      0, 0, 0, 0);
    vecs[3]  = mk(7, 5, 1, 7, 'hAAAA, 1, 7, 'hBBBB, 0, 0, 0, 'hBBBB, 'h1234, 0, 0, 0, 0);
    vecs[4]  = mk(7, 7, 0, 0, 0,      0, 0, 0,      0, 0, 0, 'hBBBB, 'hBBBB, 0, 0, 0, 0);
    vecs[5]  = mk(3, 5, 0, 0, 0,      0, 0, 0,      1, 3, 0, 0,      'h1234, 0, 0, 0, 1);
    vecs[6]  = mk(3, 3, 0, 0, 0,      0, 0, 0,      1, 3, 0, 0,      0,      1, 1, 1, 1);
    vecs[7]  = mk(3, 7, 0, 0, 0,      1, 3, 'h55,   1, 3, 0, 'h55,   'hBBBB, 0, 0, 0, 1);
    vecs[8]  = mk(3, 3, 0, 0, 0,      0, 0, 0,      0, 0, 0, 'h55,   'h55,   1, 1, 0, 1);
    vecs[9]  = mk(5, 3, 0, 0, 0,      1, 3, 'h66,   0, 0, 0, 'h1234, 'h66,   0, 0, 0, 0);
    vecs[10] = mk(1, 3, 0, 0, 0,      0, 0, 0,      1, 1, 0, 0,      'h66,   0, 0, 0, 1);
    vecs[11] = mk(1, 2, 0, 0, 0,      0, 0, 0,      1, 2, 0, 0,      0,      1, 0, 0, 2);
    vecs[12] = mk(2, 4, 0, 0, 0,      0, 0, 0,      1, 4, 0, 0,      0,      1, 0, 0, 3);
    vecs[13] = mk(9, 4, 0, 0, 0,      0, 0, 0,      1, 9, 1, 0,      0,      0, 1, 0, 1);
    vecs[14] = mk(9, 1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0,      1, 0, 0, 1);
    vecs[15] = mk(0, 0, 1, 0, 'hFFFF, 0, 0, 0,      1, 0, 0, 0,      0,      0, 0, 0, 1);
    vecs[16] = mk(0, 9, 0, 0, 0,      0, 0, 0,      1, 9, 0, 0,      0,      0, 1, 1, 1);
    vecs[17] = mk(9, 9, 1, 9, 'h11,   1, 9, 'h99,   0, 0, 0, 'h99,   'h99,   0, 0, 0, 0);
    vecs[18] = mk(10, 9, 0, 0, 0,     1, 10, 'hA0,  0, 0, 0, 'hA0,   'h99,   0, 0, 0, 0);
    vecs[19] = mk(10, 0, 0, 0, 0,     0, 0, 0,      0, 0, 0, 'hA0,   0,      0, 0, 0, 0);
    vecs[20] = mk(0, 5, 1, 5, 'h5A5A, 1, 0, 'h77,   0, 0, 0, 0,      'h5A5A, 0, 0, 0, 0);
    vecs[21] = mk(0, 5, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      'h5A5A, 0, 0, 0, 0);

    idle();
    reset_n = 1'b0;
    #22;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Post-reset: every address reads 0 and is idle
    chk("reset_cnt", 32'(bus.busy_cnt), 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd1[%0d]", i), bus.rd1, 32'd0);
      chk($sformatf("reset_rd2[%0d]", 31 - i), bus.rd2, 32'd0);
      chk($sformatf("reset_busy1[%0d]", i), 32'(bus.busy1), 32'd0);
      chk($sformatf("reset_busy2[%0d]", 31 - i), 32'(bus.busy2), 32'd0);
    end
    chk("reset_stall", 32'(bus.iss_stall), 32'd0);
    @(posedge clk); #1;

    // Directed vector table
    for (int k = 0; k < 22; k++) begin
      bus.ra1 = vecs[k].ra1; bus.ra2 = vecs[k].ra2;
      bus.we_a = vecs[k].we_a; bus.wa_a = vecs[k].wa_a; bus.wd_a = vecs[k].wd_a;
      bus.we_b = vecs[k].we_b; bus.wa_b = vecs[k].wa_b; bus.wd_b = vecs[k].wd_b;
      bus.iss_v = vecs[k].iss_v; bus.iss_d = vecs[k].iss_d; bus.flush = vecs[k].flush;
      #1;
      chk($sformatf("v%0d_rd1", k), bus.rd1, vecs[k].e_rd1);
      chk($sformatf("v%0d_rd2", k), bus.rd2, vecs[k].e_rd2);
      chk($sformatf("v%0d_busy1", k), 32'(bus.busy1), 32'(vecs[k].e_b1));
      chk($sformatf("v%0d_busy2", k), 32'(bus.busy2), 32'(vecs[k].e_b2));
      chk($sformatf("v%0d_stall", k), 32'(bus.iss_stall), 32'(vecs[k].e_st));
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", k), 32'(bus.busy_cnt), 32'(vecs[k].e_cnt));
      idle();
    end

    // Mid-operation reset: state clears asynchronously, in-flight ops dropped
    bus.iss_v = 1'b1; bus.iss_d = 5'd12;
    @(posedge clk); #1;
    idle();
    chk("mr_cnt_before", 32'(bus.busy_cnt), 32'd1);
    bus.ra1 = 5'd5; bus.ra2 = 5'd12;
    #1;
    chk("mr_rd1_before", bus.rd1, 32'h5A5A);
    chk("mr_busy2_before", 32'(bus.busy2), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_rd1_async", bus.rd1, 32'd0);
    chk("mr_busy2_async", 32'(bus.busy2), 32'd0);
    chk("mr_cnt_async", 32'(bus.busy_cnt), 32'd0);
    bus.we_a = 1'b1; bus.wa_a = 5'd7; bus.wd_a = 32'hDEAD;
    bus.iss_v = 1'b1; bus.iss_d = 5'd7;
    @(posedge clk); #1;
    idle();
    reset_n = 1'b1;
    bus.ra1 = 5'd7; bus.ra2 = 5'd7;
    #1;
    chk("mr_rd1_dropped", bus.rd1, 32'd0);
    chk("mr_busy1_dropped", 32'(bus.busy1), 32'd0);
    @(posedge clk); #1;
    chk("mr_cnt_after", 32'(bus.busy_cnt), 32'd0);
    chk("mr_rd2_after", bus.rd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write three-port register file.
- Two combinational read ports with same-cycle write-to-read bypass.
- Two write ports: A is the single-cycle ALU writeback; B is the multicycle/load writeback.
- Per-register scoreboard of busy bits, so issue logic can stall on pending destinations.
- Sits between decode/issue and the writeback stages of the pipelined MIPS core.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(DEPTH): register address width; derived, not overridden.
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  WIDTH  read data, port 1 (combinational)
- rd2  out  WIDTH  read data, port 2 (combinational)
- busy1  out  1  register ra1 has a pending write (combinational)
- busy2  out  1  register ra2 has a pending write (combinational)
- we_a  in  1  write enable, port A
- wa_a  in  AW  write address, port A
- wd_a  in  WIDTH  write data, port A
- we_b  in  1  write enable, port B; also clears busy[wa_b]
- wa_b  in  AW  write address, port B
- wd_b  in  WIDTH  write data, port B
- iss_v  in  1  issue request: claim destination iss_d
- iss_d  in  AW  destination to mark busy
- iss_stall  out  1  issue refused this cycle (combinational)
- flush  in  1  synchronous clear of all busy bits
- busy_cnt  out  AW+1  number of busy registers (registered)

Behaviour:
- Reset (reset_n low, asynchronous): all registers go to 0, all busy bits to 0, busy_cnt to 0.
- Reset effects on outputs: rd1/rd2 read 0, busy1/busy2 read 0, iss_stall follows its combinational rule.
- Reset mid-operation: pending writes and issues in that cycle are discarded.
- Writes: registers update on the rising edge of clk when we_a/we_b is high.
- Same-address collision: if we_a and we_b target the same address in one cycle, port B wins.
- Read bypass: rd1 returns the write data when its address matches an active write port this cycle, with B taking priority over A; otherwise it returns the stored value. rd2 follows the same rule.
- Read latency: effectively 0 cycles, including for data being written in the same cycle.
- ZERO_REG=1 behaviour for address 0:
  - reads return 0 even when bypassing;
  - writes are dropped;
  - iss_v with iss_d=0 is always accepted and never sets a busy bit;
  - busy1/busy2 are 0 for address 0.
- iss_stall = iss_v & busy[iss_d] & ~(we_b & wa_b==iss_d). A write-back clearing the same register in the same cycle unblocks the issue.
- Busy-bit next state, evaluated per register, in this order:
  - flush clears all bits, then
  - we_b clears bit wa_b, then
  - an accepted issue (iss_v & ~iss_stall) sets bit iss_d.
- Consequences of that ordering:
  - A same-cycle clear and issue on one register leaves it busy.
  - flush together with an accepted issue leaves only iss_d busy.
- Port A never changes busy bits. A single-cycle writer must not issue through the scoreboard.
- busy1/busy2 reflect registered busy state, except that a we_b to the same address in the current cycle forces them to 0, consistent with the bypass.
- busy_cnt is the registered population count of the busy bits after the update, ranging 0..DEPTH.
- A we_b to a non-busy register is legal: data is written and the busy bit stays 0.

Decomposition:
- Shared package mips_pkg holds:
  - the WIDTH/DEPTH defaults;
  - the zero-register address constant;
  - the typedefs reg_addr_t and word_t.
- One sub-module, sb_bits, holds the DEPTH-bit busy vector, the flush/clear/set ordering and the popcount.
- The register array, the bypass muxes and the stall logic stay in regfile_sb.

Test Plan:
- Reset release, then read every address -> rd=0, busy=0, busy_cnt=0.
- we_a=1, wa_a=5, wd_a=0x1234 with ra1=5 in the same cycle -> rd1=0x1234 combinationally; next cycle rd1=0x1234 from storage.
- we_a=1 and we_b=1 both to r7 (A=0xAAAA, B=0xBBBB) -> same-cycle bypass and stored value both 0xBBBB.
- Issue r3 -> busy_cnt=1, ra1=3 gives busy1=1. Issue r3 again -> iss_stall=1, busy_cnt stays 1. we_b to r3 with 0x55 plus a concurrent issue of r3 -> iss_stall=0, r3 stays busy, rd1=0x55.
- Issue r1, r2, r4 over 3 cycles -> busy_cnt=3. Then flush with issue of r9 in the same cycle -> busy_cnt=1, only r9 busy.
- we_a to r0 with 0xFFFF and issue of r0 -> rd1(ra1=0)=0, busy_cnt unchanged. reset_n pulsed low mid-sequence -> all state is 0 immediately, without waiting for a clock edge.
